// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory access controller.
//   DEFAULT_DEPTH : default number of instruction words
//   NOP_INSTR     : instruction returned on a faulting fetch (addi x0,x0,0)
//   state_e       : controller state, zero-fill (ST_CLEAR) or serving (ST_RUN)
//   addr_ok()     : true when a byte address is word aligned and inside the array
package imem_pkg;

  localparam int unsigned DEFAULT_DEPTH = 1024;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic logic addr_ok(input logic [31:0] byte_addr, input int unsigned depth);
    return (byte_addr[1:0] == 2'b00) && ({2'b00, byte_addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/imem_rr_arbiter.sv
// Two-requester round-robin arbiter.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (pointer returns to requester 0)
//   en_i   : arbitration enabled; no grants while low
//   req_i  : request vector, bit 0 = fetch, bit 1 = loader
//   gnt_o  : one-hot (or zero) grant vector, combinational from req_i and pointer
module imem_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;
  logic contested;

  // A requester wins when it is alone, or when it owns the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt_o[gi] = en_i & req_i[gi] & (~req_i[1-gi] | (ptr_q == 1'(gi)));
    end
  endgenerate

  // The pointer only moves on a contested grant: it hands priority to the loser.
  assign contested = en_i & req_i[0] & req_i[1];

  always_comb begin
    ptr_d = ptr_q;
    if (contested) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/imem_access_ctrl.sv
// Instruction-memory access controller: zero-fills the single-port RAM after
// reset, then shares it round-robin between the fetch stage and the loader.
//   SYS_clk/SYS_reset_n : clock, asynchronous active-low reset
//   fetch_*             : IF request (byte PC), grant, 1-cycle response pulse
//   load_*              : loader write request, grant, 1-cycle drop-error pulse
//   init_done           : zero-fill finished, memory usable
//   mem_*               : RAM macro port (read data valid the cycle after a read)
module imem_access_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int          ADDR_W = $clog2(DEPTH),
  parameter int          DATA_W = 32
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault,
  input  logic              load_req,
  input  logic [31:0]       load_addr,
  input  logic [DATA_W-1:0] load_wdata,
  output logic              load_gnt,
  output logic              load_err,
  output logic              init_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              init_done_q, init_done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic              load_err_q, load_err_d;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              run;
  logic              fetch_ok;
  logic              load_ok;
  logic              mem_en_c;
  logic              mem_we_c;

  assign run      = (state_q == ST_RUN);
  assign req      = {load_req, fetch_req};
  assign fetch_ok = addr_ok(fetch_addr, DEPTH);
  assign load_ok  = addr_ok(load_addr, DEPTH);

  imem_rr_arbiter u_arb (
    .clk_i  (SYS_clk),
    .rst_ni (SYS_reset_n),
    .en_i   (run),
    .req_i  (req),
    .gnt_o  (gnt)
  );

  assign fetch_gnt = gnt[0];
  assign load_gnt  = gnt[1];

  // Next state, clear counter and RAM port drive.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_en_c  = 1'b0;
    mem_we_c  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_en_c  = 1'b1;
        mem_we_c  = 1'b1;
        mem_addr  = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Bad addresses are still granted but never reach the RAM.
        if (gnt[0] && fetch_ok) begin
          mem_en_c = 1'b1;
          mem_addr = fetch_addr[ADDR_W+1:2];
        end else if (gnt[1] && load_ok) begin
          mem_en_c  = 1'b1;
          mem_we_c  = 1'b1;
          mem_addr  = load_addr[ADDR_W+1:2];
          mem_wdata = load_wdata;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Reset is combined in so the RAM sees no enable at all while reset is held,
  // even though the state register already sits in ST_CLEAR.
  assign mem_en = mem_en_c & SYS_reset_n;
  assign mem_we = mem_we_c & SYS_reset_n;

  // Response pipeline: the RAM answers one cycle after the grant.
  always_comb begin
    init_done_d = (state_d == ST_RUN);
    rsp_valid_d = gnt[0];
    rsp_fault_d = gnt[0] & ~fetch_ok;
    load_err_d  = gnt[1] & ~load_ok;
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      load_err_q  <= load_err_d;
    end
  end

  assign init_done   = init_done_q;
  assign fetch_valid = rsp_valid_q;
  assign fetch_fault = rsp_fault_q;
  assign load_err    = load_err_q;
  assign fetch_instr = !rsp_valid_q ? '0 :
                       rsp_fault_q  ? DATA_W'(NOP_INSTR) : mem_rdata;

endmodule

// File: tb/tb_imem_access_ctrl.sv
module tb_imem_access_ctrl;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch_req = 1'b0;
  logic [31:0]       fetch_addr = '0;
  logic              fetch_gnt, fetch_valid, fetch_fault;
  logic [DATA_W-1:0] fetch_instr;
  logic              load_req = 1'b0;
  logic [31:0]       load_addr = '0;
  logic [DATA_W-1:0] load_wdata = '0;
  logic              load_gnt, load_err, init_done;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  // Reference state: memory image and which side wins the next contest.
  logic [31:0] model_mem [DEPTH];
  bit          fetch_has_turn = 1'b1;

  always #5 clk = ~clk;

  imem_access_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .SYS_clk     (clk),
    .SYS_reset_n (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .load_req    (load_req),
    .load_addr   (load_addr),
    .load_wdata  (load_wdata),
    .load_gnt    (load_gnt),
    .load_err    (load_err),
    .init_done   (init_done),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Single-port synchronous RAM macro model.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs are driven 1ns after the rising edge, outputs sampled 1ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic bit good_addr(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DEPTH);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    if (r == 1) return 32'(4 * DEPTH + $urandom_range(0, 64));
    return 32'($urandom_range(0, 15) * 4);
  endfunction

  task automatic test_reset();
    fetch_req = 1'b1;
    load_req  = 1'b1;
    load_addr = 32'h20;
    rst_n     = 1'b0;
    repeat (3) next_cycle();
    #1;
    checks++;
    if ({fetch_gnt, fetch_valid, fetch_fault, load_gnt, load_err, init_done, mem_en, mem_we} !== 8'b0 ||
        fetch_instr !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ctl=%b instr=%h addr=%h wdata=%h want all zero",
               {fetch_gnt, fetch_valid, fetch_fault, load_gnt, load_err, init_done, mem_en, mem_we},
               fetch_instr, mem_addr, mem_wdata);
    end
    fetch_req = 1'b0;
    load_req  = 1'b0;
    $display("txn reset held 3 cycles, outputs sampled");
  endtask

  // Releases reset and follows the whole zero-fill; optionally holds a fetch
  // of PC 0 throughout, which must only be granted once the fill is over.
  task automatic test_fill(input bit early_fetch);
    int we_cnt, bad, rise, early_gnt, cyc;
    we_cnt = 0; bad = 0; rise = 0; early_gnt = 0;
    fetch_req  = early_fetch;
    fetch_addr = 32'h0;
    load_req   = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    #1;
    for (cyc = 1; cyc <= DEPTH + 4; cyc++) begin
      if (init_done === 1'b1) begin
        rise = cyc;
        break;
      end
      if (mem_en === 1'b1 && mem_we === 1'b1) begin
        we_cnt++;
        if (mem_addr !== ADDR_W'(cyc - 1) || mem_wdata !== '0) bad++;
      end else begin
        bad++;
      end
      if (fetch_gnt !== 1'b0 || load_gnt !== 1'b0) early_gnt++;
      next_cycle();
      #1;
    end
    checks++;
    if (we_cnt != DEPTH) begin
      failures++;
      $display("FAIL fill_we_cycles: got %0d want %0d", we_cnt, DEPTH);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL fill_addr_data: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (rise != DEPTH + 1) begin
      failures++;
      $display("FAIL init_done_cycle: got %0d want %0d", rise, DEPTH + 1);
    end
    checks++;
    if (early_gnt != 0) begin
      failures++;
      $display("FAIL grant_during_clear: got %0d grants want 0", early_gnt);
    end
    if (early_fetch) begin
      checks++;
      if (fetch_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0) begin
        failures++;
        $display("FAIL first_fetch_gnt: got gnt=%b en=%b we=%b addr=%h want 1 1 0 0",
                 fetch_gnt, mem_en, mem_we, mem_addr);
      end
      next_cycle();
      fetch_req = 1'b0;
      #1;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_fault !== 1'b0 || fetch_instr !== 32'h0) begin
        failures++;
        $display("FAIL first_fetch_data: got v=%b f=%b instr=%h want 1 0 00000000",
                 fetch_valid, fetch_fault, fetch_instr);
      end
    end else begin
      checks++;
      if (mem_we !== 1'b0) begin
        failures++;
        $display("FAIL fill_stop: got mem_we=%b want 0 after fill", mem_we);
      end
    end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    fetch_has_turn = 1'b1;
    $display("txn fill done: writes=%0d init_done at cycle %0d early_fetch=%0d", we_cnt, rise, early_fetch);
  endtask

  task automatic test_contention();
    bit exp_f, prev_v;
    logic [31:0] prev_i;
    prev_v = 1'b0; prev_i = '0;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      fetch_req  = 1'b1;
      fetch_addr = 32'h20;
      load_req   = 1'b1;
      load_addr  = 32'h40;
      load_wdata = 32'hC0DE_0000 + 32'(k);
      #1;
      exp_f = fetch_has_turn;
      checks++;
      if (fetch_gnt !== exp_f || load_gnt !== !exp_f) begin
        failures++;
        $display("FAIL contest_grant[%0d]: got F=%b L=%b want F=%b L=%b", k, fetch_gnt, load_gnt, exp_f, !exp_f);
      end
      checks++;
      if (fetch_valid !== prev_v || (prev_v && fetch_instr !== prev_i)) begin
        failures++;
        $display("FAIL contest_rsp[%0d]: got v=%b instr=%h want v=%b instr=%h", k, fetch_valid, fetch_instr, prev_v, prev_i);
      end
      prev_v = exp_f;
      prev_i = model_mem[8];
      if (!exp_f) model_mem[16] = load_wdata;
      fetch_has_turn = !fetch_has_turn;
      $display("txn contest %0d granted %s", k, exp_f ? "F" : "L");
    end
    next_cycle();
    fetch_req = 1'b0;
    load_req  = 1'b0;
    #1;
    checks++;
    if (fetch_valid !== prev_v) begin
      failures++;
      $display("FAIL contest_last_rsp: got v=%b want %b", fetch_valid, prev_v);
    end
  endtask

  task automatic test_load_then_fetch();
    next_cycle();
    load_req   = 1'b1;
    load_addr  = 32'h10;
    load_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (load_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ADDR_W'(4) || mem_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL load_write: got gnt=%b we=%b addr=%h wdata=%h want 1 1 004 deadbeef",
               load_gnt, mem_we, mem_addr, mem_wdata);
    end
    model_mem[4] = 32'hDEAD_BEEF;
    next_cycle();
    load_req   = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h10;
    #1;
    checks++;
    if (fetch_gnt !== 1'b1 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL raw_fetch_gnt: got gnt=%b load_err=%b want 1 0", fetch_gnt, load_err);
    end
    next_cycle();
    fetch_req = 1'b0;
    #1;
    checks++;
    if (fetch_valid !== 1'b1 || fetch_fault !== 1'b0 || fetch_instr !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL raw_fetch_data: got v=%b f=%b instr=%h want 1 0 deadbeef", fetch_valid, fetch_fault, fetch_instr);
    end
    $display("txn load deadbeef @10 then fetch @10 -> %h", fetch_instr);
  endtask

  task automatic test_faults();
    logic [31:0] bad_pc [2];
    bad_pc[0] = 32'h12;
    bad_pc[1] = 32'(4 * DEPTH);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      fetch_req  = 1'b1;
      fetch_addr = bad_pc[k];
      #1;
      checks++;
      if (fetch_gnt !== 1'b1 || mem_en !== 1'b0) begin
        failures++;
        $display("FAIL fault_gnt[%0d]: got gnt=%b mem_en=%b want 1 0", k, fetch_gnt, mem_en);
      end
      next_cycle();
      fetch_req = 1'b0;
      #1;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_fault !== 1'b1 || fetch_instr !== NOP) begin
        failures++;
        $display("FAIL fault_rsp[%0d]: got v=%b f=%b instr=%h want 1 1 00000013", k, fetch_valid, fetch_fault, fetch_instr);
      end
      $display("txn fetch %h -> fault=%b instr=%h", bad_pc[k], fetch_fault, fetch_instr);
    end
    next_cycle();
    load_req   = 1'b1;
    load_addr  = 32'h2;
    load_wdata = 32'hBAD0_BAD0;
    #1;
    checks++;
    if (load_gnt !== 1'b1 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL bad_load_gnt: got gnt=%b mem_en=%b want 1 0", load_gnt, mem_en);
    end
    next_cycle();
    load_req   = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    #1;
    checks++;
    if (load_err !== 1'b1 || fetch_gnt !== 1'b1) begin
      failures++;
      $display("FAIL bad_load_err: got err=%b gnt=%b want 1 1", load_err, fetch_gnt);
    end
    next_cycle();
    fetch_req = 1'b0;
    #1;
    checks++;
    if (load_err !== 1'b0 || fetch_valid !== 1'b1 || fetch_instr !== model_mem[0]) begin
      failures++;
      $display("FAIL bad_load_ram: got err=%b v=%b word0=%h want 0 1 %h", load_err, fetch_valid, fetch_instr, model_mem[0]);
    end
    $display("txn load @2 dropped, word0=%h", fetch_instr);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      load_req   = 1'b1;
      load_addr  = 32'((32 + k) * 4);
      load_wdata = $urandom;
      #1;
      checks++;
      if (load_gnt !== 1'b1) begin
        failures++;
        $display("FAIL b2b_load_gnt[%0d]: got %b want 1", k, load_gnt);
      end
      model_mem[32 + k] = load_wdata;
    end
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      load_req   = 1'b0;
      fetch_req  = (k < 4);
      fetch_addr = 32'((32 + k) * 4);
      #1;
      if (k < 4) begin
        checks++;
        if (fetch_gnt !== 1'b1) begin
          failures++;
          $display("FAIL b2b_fetch_gnt[%0d]: got %b want 1", k, fetch_gnt);
        end
      end
      if (k > 0) begin
        checks++;
        if (fetch_valid !== 1'b1 || fetch_instr !== model_mem[32 + k - 1]) begin
          failures++;
          $display("FAIL b2b_fetch_data[%0d]: got v=%b instr=%h want 1 %h", k - 1, fetch_valid, fetch_instr, model_mem[32 + k - 1]);
        end
        $display("txn b2b fetch word %0d -> %h", 32 + k - 1, fetch_instr);
      end
    end
  endtask

  task automatic test_random(input int n);
    bit f_pend, l_pend, eg_f, eg_l, both, exp_v, exp_f, exp_le;
    logic [31:0] f_a, l_a, l_d, exp_i;
    int bad_words;
    f_pend = 0; l_pend = 0; exp_v = 0; exp_f = 0; exp_le = 0;
    f_a = '0; l_a = '0; l_d = '0; exp_i = '0;
    for (int c = 0; c <= n; c++) begin
      next_cycle();
      if (c < n && !f_pend && $urandom_range(0, 2) != 0) begin f_pend = 1; f_a = rand_addr(); end
      if (c < n && !l_pend && $urandom_range(0, 2) == 0) begin l_pend = 1; l_a = rand_addr(); l_d = $urandom; end
      fetch_req  = f_pend;
      fetch_addr = f_pend ? f_a : $urandom;
      load_req   = l_pend;
      load_addr  = l_pend ? l_a : $urandom;
      load_wdata = l_pend ? l_d : $urandom;
      #1;
      checks++;
      if (fetch_valid !== exp_v || (exp_v && (fetch_fault !== exp_f || fetch_instr !== exp_i)) || load_err !== exp_le) begin
        failures++;
        $display("FAIL rand_rsp[%0d]: got v=%b f=%b instr=%h lerr=%b want v=%b f=%b instr=%h lerr=%b",
                 c, fetch_valid, fetch_fault, fetch_instr, load_err, exp_v, exp_f, exp_i, exp_le);
      end
      both = f_pend && l_pend;
      eg_f = f_pend && (!l_pend || fetch_has_turn);
      eg_l = l_pend && !eg_f;
      checks++;
      if (fetch_gnt !== eg_f || load_gnt !== eg_l) begin
        failures++;
        $display("FAIL rand_gnt[%0d]: got F=%b L=%b want F=%b L=%b", c, fetch_gnt, load_gnt, eg_f, eg_l);
      end
      exp_v = eg_f; exp_f = 0; exp_le = 0;
      if (eg_f) begin
        exp_f  = !good_addr(f_a);
        exp_i  = exp_f ? NOP : model_mem[f_a / 4];
        f_pend = 0;
        $display("txn rand %0d fetch %h -> %s", c, f_a, exp_f ? "fault" : "ok");
      end
      if (eg_l) begin
        if (good_addr(l_a)) model_mem[l_a / 4] = l_d;
        exp_le = !good_addr(l_a);
        l_pend = 0;
        $display("txn rand %0d load %h = %h -> %s", c, l_a, l_d, exp_le ? "dropped" : "ok");
      end
      if (both) fetch_has_turn = !fetch_has_turn;
    end
    fetch_req = 1'b0;
    load_req  = 1'b0;
    bad_words = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== model_mem[i]) bad_words++;
    checks++;
    if (bad_words != 0) begin
      failures++;
      $display("FAIL ram_image: got %0d differing words want 0", bad_words);
    end
  endtask

  task automatic test_reset_midfetch();
    next_cycle();
    fetch_req  = 1'b1;
    fetch_addr = 32'h10;
    #1;
    checks++;
    if (fetch_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midfetch_gnt: got %b want 1", fetch_gnt);
    end
    #1;
    rst_n     = 1'b0;
    fetch_req = 1'b0;
    next_cycle();
    checks++;
    if (fetch_valid !== 1'b0 || fetch_instr !== '0) begin
      failures++;
      $display("FAIL midfetch_suppress: got v=%b instr=%h want 0 0", fetch_valid, fetch_instr);
    end
    $display("txn reset during fetch, response suppressed");
    next_cycle();
  endtask

  task automatic test_reset_midfill();
    bit found;
    found = 0;
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < DEPTH; c++) begin
      if (mem_we === 1'b1 && mem_addr === ADDR_W'(500)) begin
        found = 1;
        break;
      end
      next_cycle();
      #1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midfill_reach: got no write to word 500 want one");
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fetch_gnt, fetch_valid, fetch_fault, load_gnt, load_err, init_done, mem_en, mem_we} !== 8'b0 ||
        fetch_instr !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL midfill_outputs: got ctl=%b addr=%h want all zero",
               {fetch_gnt, fetch_valid, fetch_fault, load_gnt, load_err, init_done, mem_en, mem_we}, mem_addr);
    end
    $display("txn reset at fill word 500, outputs cleared");
    next_cycle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_fill(1'b1);
    test_contention();
    test_load_then_fetch();
    test_faults();
    test_back_to_back();
    test_random(400);
    test_reset_midfetch();
    test_fill(1'b0);
    test_reset_midfill();
    test_fill(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
